// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider sequencer: state encoding,
// multiplier mux-select codes and the legal-range check for the iteration count.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IA_N = 3'd1,
        IA_D = 3'd2,
        IT_A = 3'd3,
        IT_B = 3'd4,
        REM  = 3'd5,
        DONE = 3'd6
    } fpdiv_state_t;

    localparam logic [1:0] SEL3_IA    = 2'd0;
    localparam logic [1:0] SEL3_REGC  = 2'd1;
    localparam logic [1:0] SEL3_DENOM = 2'd2;

    localparam logic [1:0] SEL4_NUM   = 2'd0;
    localparam logic [1:0] SEL4_DENOM = 2'd1;
    localparam logic [1:0] SEL4_REGA  = 2'd2;
    localparam logic [1:0] SEL4_REGB  = 2'd3;

    // The iteration counter is 3 bits wide, so more than 7 iterations cannot be tracked.
    function automatic bit iters_legal(input int n);
        return (n >= 1) && (n <= 7);
    endfunction

endpackage

// File: rtl/fpdiv_seq_ctrl_if.sv
// Issue/result handshake and datapath control bundle between the FP issue logic,
// the sequencer and the divider datapath. dbg_state exposes the sequencer state.
interface fpdiv_seq_ctrl_if #(parameter int WIDTH = 32);
    import fpdiv_pkg::*;

    // in_*: transfer when in_valid & in_ready at a rising edge; out_*: transfer when
    // out_valid & out_ready at a rising edge; valid never depends on ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_denom;
    logic             in_rm;
    logic [WIDTH-1:0] op_num;
    logic [WIDTH-1:0] op_denom;
    logic             op_rm;
    logic             en_a;
    logic             en_b;
    logic             en_rem;
    logic [1:0]       sel_mux3;
    logic [1:0]       sel_mux4;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    fpdiv_state_t     dbg_state;

    modport master (
        output in_valid, in_num, in_denom, in_rm, out_ready,
        input  in_ready, op_num, op_denom, op_rm, en_a, en_b, en_rem,
               sel_mux3, sel_mux4, out_valid, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_num, in_denom, in_rm, out_ready,
        output in_ready, op_num, op_denom, op_rm, en_a, en_b, en_rem,
               sel_mux3, sel_mux4, out_valid, busy, dbg_state
    );

endinterface

// File: rtl/fpdiv_perfcnt.sv
// Completed-division and busy-cycle counters for the divider sequencer.
// Built only when FPDIV_SEQ_PERFCNT_EN is defined.
module fpdiv_perfcnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_busy,
    input  logic        i_retire,
    output logic [31:0] o_perf_ops,
    output logic [31:0] o_perf_busy
);

    logic [31:0] r_ops;
    logic [31:0] r_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ops  <= '0;
            r_busy <= '0;
        end else begin
            if (i_retire) r_ops  <= r_ops + 32'd1;
            if (i_busy)   r_busy <= r_busy + 32'd1;
        end
    end

    assign o_perf_ops  = r_ops;
    assign o_perf_busy = r_busy;

endmodule

// File: rtl/fpdiv_seq_ctrl.sv
// Sequencer for the Goldschmidt mantissa divider: latches operands, steps the datapath
// through approximation/iteration/remainder passes. Optional counters: FPDIV_SEQ_PERFCNT_EN.
module fpdiv_seq_ctrl
    import fpdiv_pkg::*;
#(
    parameter int ITERS = 3,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    fpdiv_seq_ctrl_if.slave      bus
`ifdef FPDIV_SEQ_PERFCNT_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_busy
`endif
);

    if (!iters_legal(ITERS)) begin : g_iters_bad
        $error("fpdiv_seq_ctrl: ITERS must be in 1..7");
    end

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    fpdiv_state_t     r_state;
    fpdiv_state_t     w_next_state;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_denom;
    logic             r_rm;

    logic       w_accept;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_en_a;
    logic       w_en_b;
    logic       w_en_rem;
    logic [1:0] w_sel3;
    logic [1:0] w_sel4;

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_num   <= '0;
            r_denom <= '0;
            r_rm    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_num   <= bus.in_num;
                r_denom <= bus.in_denom;
                r_rm    <= bus.in_rm;
                r_cnt   <= '0;
            end else if (r_state == IT_A) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Control outputs depend on r_state only; inputs affect just the next state.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_en_a       = 1'b0;
        w_en_b       = 1'b0;
        w_en_rem     = 1'b0;
        w_sel3       = SEL3_IA;
        w_sel4       = SEL4_NUM;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next_state = IA_N;
            end
            IA_N: begin
                w_en_a       = 1'b1;
                w_sel3       = SEL3_IA;
                w_sel4       = SEL4_NUM;
                w_next_state = IA_D;
            end
            IA_D: begin
                w_en_b       = 1'b1;
                w_sel3       = SEL3_IA;
                w_sel4       = SEL4_DENOM;
                w_next_state = IT_A;
            end
            IT_A: begin
                w_en_a       = 1'b1;
                w_sel3       = SEL3_REGC;
                w_sel4       = SEL4_REGA;
                w_next_state = (r_cnt == LAST_ITER) ? REM : IT_B;
            end
            IT_B: begin
                w_en_b       = 1'b1;
                w_sel3       = SEL3_REGC;
                w_sel4       = SEL4_REGB;
                w_next_state = IT_A;
            end
            REM: begin
                w_en_rem     = 1'b1;
                w_sel3       = SEL3_DENOM;
                w_sel4       = SEL4_REGA;
                w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.en_a      = w_en_a;
    assign bus.en_b      = w_en_b;
    assign bus.en_rem    = w_en_rem;
    assign bus.sel_mux3  = w_sel3;
    assign bus.sel_mux4  = w_sel4;
    assign bus.op_num    = r_num;
    assign bus.op_denom  = r_denom;
    assign bus.op_rm     = r_rm;
    assign bus.busy      = (r_state != IDLE);
    assign bus.dbg_state = r_state;

`ifdef FPDIV_SEQ_PERFCNT_EN
    fpdiv_perfcnt u_perfcnt (
        .clk         (clk),
        .reset       (reset),
        .i_busy      (r_state != IDLE),
        .i_retire    ((r_state == DONE) && bus.out_ready),
        .o_perf_ops  (perf_ops),
        .o_perf_busy (perf_busy)
    );
`endif

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Scoreboard bench for fpdiv_seq_ctrl: an ITERS=3 instance under directed traffic and
// an ITERS=1 instance for the short sequence. Perf counters checked under FPDIV_SEQ_PERFCNT_EN.
module tb_fpdiv_seq_ctrl;
  import fpdiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  fpdiv_seq_ctrl_if #(.WIDTH(W)) bus ();
  fpdiv_seq_ctrl_if #(.WIDTH(W)) bus1 ();

`ifdef FPDIV_SEQ_PERFCNT_EN
  logic [31:0] perf_ops, perf_busy, perf_ops1, perf_busy1;
`endif

  fpdiv_seq_ctrl #(.ITERS(3), .WIDTH(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave)
`ifdef FPDIV_SEQ_PERFCNT_EN
    ,
    .perf_ops  (perf_ops),
    .perf_busy (perf_busy)
`endif
  );

  fpdiv_seq_ctrl #(.ITERS(1), .WIDTH(W)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1.slave)
`ifdef FPDIV_SEQ_PERFCNT_EN
    ,
    .perf_ops  (perf_ops1),
    .perf_busy (perf_busy1)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [2*W:0] exp_q[$];
  int           acc_q[$];
  logic [7:0]   trace_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  // control word {en_a, en_b, en_rem, sel_mux3, sel_mux4, out_valid}
  function automatic logic [7:0] cw(input logic a, input logic b, input logic r,
                                    input logic [1:0] s3, input logic [1:0] s4);
    return {a, b, r, s3, s4, 1'b0};
  endfunction

  task automatic push_expected(input logic [W-1:0] num, input logic [W-1:0] den, input logic rm);
    exp_q.push_back({num, den, rm});
    acc_q.push_back(cyc);
    trace_q.push_back(cw(1, 0, 0, 2'd0, 2'd0));
    trace_q.push_back(cw(0, 1, 0, 2'd0, 2'd1));
    for (int i = 0; i < 3; i++) begin
      trace_q.push_back(cw(1, 0, 0, 2'd1, 2'd2));
      if (i < 2) trace_q.push_back(cw(0, 1, 0, 2'd1, 2'd3));
    end
    trace_q.push_back(cw(0, 0, 1, 2'd2, 2'd2));
  endtask

  // ---------------- monitor (ITERS=3 instance) ----------------
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.busy && !bus.out_valid) begin
        if (trace_q.size() == 0)
          fail_now("trace_extra", "work state with no expected control word");
        else
          check("trace", {bus.en_a, bus.en_b, bus.en_rem, bus.sel_mux3, bus.sel_mux4, bus.out_valid},
                trace_q.pop_front());
      end
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) fail_now("latency", "out_valid with nothing outstanding");
        else check("latency", 128'(cyc - acc_q[0]), 128'(9));
        check("done_enables", {bus.en_a, bus.en_b, bus.en_rem}, 3'b000);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("result", "retire with empty queue");
        else begin
          check("result_ops", {bus.op_num, bus.op_denom, bus.op_rm}, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  logic seen_itb1 = 1'b0;
  always @(negedge clk) if (reset && bus1.dbg_state == IT_B) seen_itb1 = 1'b1;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] num, input logic [W-1:0] den, input logic rm);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    bus.in_denom = den;
    bus.in_rm    = rm;
    for (int i = 0; i < 60 && !done; i++) begin
      if (bus.in_ready) begin
        push_expected(num, den, rm);
        done = 1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) fail_now("issue", "in_ready never seen");
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.dbg_state == IDLE && exp_q.size() == 0) done = 1;
      else step();
    end
    if (!done) fail_now("wait_idle", "did not return to IDLE");
  endtask

  task automatic wait_state(input fpdiv_state_t s);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.dbg_state == s) done = 1;
      else step();
    end
    if (!done) fail_now("wait_state", "state never reached");
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] vec_num[3] = '{32'h3FC00000, 32'h40490FDB, 32'hC1200000};
  logic [W-1:0] vec_den[3] = '{32'h3F800000, 32'h402DF854, 32'h3E800000};
  logic         vec_rm[3]  = '{1'b1, 1'b0, 1'b1};

  initial begin
    int t0;
    bit done;
    fpdiv_state_t last_state;

    bus.in_valid = 0; bus.in_num = '0; bus.in_denom = '0; bus.in_rm = 0; bus.out_ready = 1;
    bus1.in_valid = 0; bus1.in_num = '0; bus1.in_denom = '0; bus1.in_rm = 0; bus1.out_ready = 1;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst_state", bus.dbg_state, IDLE);
    check("rst_ready_busy", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    check("rst_ops", {bus.op_num, bus.op_denom, bus.op_rm}, '0);
    check("rst_ctrl", {bus.en_a, bus.en_b, bus.en_rem, bus.sel_mux3, bus.sel_mux4}, '0);
`ifdef FPDIV_SEQ_PERFCNT_EN
    check("rst_perf", {perf_ops, perf_busy}, '0);
`endif

    // Single division 1.5 / 1.0, trace and latency checked by monitor
    issue(32'h3FC00000, 32'h3F800000, 1'b1);
    wait_idle();

    // Back-pressure: hold out_ready low in DONE, pulse in_valid
    bus.out_ready = 1'b0;
    issue(32'h3F000000, 32'h40000000, 1'b0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.out_valid) done = 1;
      else step();
    end
    if (!done) fail_now("bp_wait", "out_valid never rose");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_num   = 32'h41200000;
      bus.in_denom = 32'h41200000;
      step();
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.en_a, bus.en_b, bus.en_rem}, 5'b10000);
      check("bp_op_num", bus.op_num, 32'h3F000000);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    // Busy-drop: new operand presented during IT_A held until accepted from IDLE
    issue(32'h3FC00000, 32'h3FC00000, 1'b0);
    wait_state(IT_A);
    bus.in_valid = 1'b1;
    bus.in_num   = 32'h40000000;
    bus.in_denom = 32'h3F800000;
    bus.in_rm    = 1'b1;
    done = 0;
    last_state = IT_A;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.in_ready) begin
        check("drop_prev_done", last_state, DONE);
        check("drop_state_idle", bus.dbg_state, IDLE);
        push_expected(32'h40000000, 32'h3F800000, 1'b1);
        done = 1;
      end else begin
        check("drop_op_num", bus.op_num, 32'h3FC00000);
      end
      last_state = bus.dbg_state;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) fail_now("drop_accept", "held operand never accepted");
    check("drop_latched", bus.op_num, 32'h40000000);
    wait_idle();

    // Directed vectors back-to-back
    for (int v = 0; v < 3; v++) issue(vec_num[v], vec_den[v], vec_rm[v]);
    wait_idle();

    // Mid-operation reset in IT_B
    issue(32'h40400000, 32'h40000000, 1'b1);
    wait_state(IT_B);
    reset = 1'b0;
    step();
    step();
    exp_q.delete();
    acc_q.delete();
    trace_q.delete();
    check("mid_rst_state", bus.dbg_state, IDLE);
    check("mid_rst_outs", {bus.en_a, bus.en_b, bus.en_rem, bus.out_valid, bus.in_ready}, 5'b00001);
    check("mid_rst_ops", bus.op_num, 32'h0);
    reset = 1'b1;
    step();

`ifdef FPDIV_SEQ_PERFCNT_EN
    check("perf_after_rst", {perf_ops, perf_busy}, '0);
    for (int v = 0; v < 4; v++) issue(32'h3FC00000 + 32'(v), 32'h3F800000, 1'b1);
    wait_idle();
    check("perf_ops", perf_ops, 32'd4);
    check("perf_busy", perf_busy, 32'd36);
`endif

    // ITERS=1 instance
    bus1.in_valid = 1'b1;
    bus1.in_num   = 32'h3FC00000;
    bus1.in_denom = 32'h3F800000;
    bus1.in_rm    = 1'b1;
    check("i1_ready", bus1.in_ready, 1'b1);
    t0 = cyc;
    step();
    bus1.in_valid = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus1.out_valid) done = 1;
      else step();
    end
    if (!done) fail_now("i1_wait", "out_valid never rose");
    check("i1_latency", 128'(cyc - t0), 128'(5));
    check("i1_ops", {bus1.op_num, bus1.op_denom, bus1.op_rm}, {32'h3FC00000, 32'h3F800000, 1'b1});
    step();
    check("i1_back_idle", bus1.dbg_state, IDLE);
    check("i1_no_itb", seen_itb1, 1'b0);

    // ---------------- report ----------------
    check("queues_empty", {32'(exp_q.size()), 32'(trace_q.size())}, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
